// File: rtl/sram2axi_pkg.sv
// Shared definitions for the sram2axi bridge: AXI IDs, fixed AR field values,
// the AR issue state encoding and the registered AR request record.
package sram2axi_pkg;

  localparam logic [3:0] ID_INST     = 4'd0;
  localparam logic [3:0] ID_DATA     = 4'd1;

  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'd0;
  localparam logic [2:0] PROT_NONE   = 3'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  id;
  } ar_req_t;

  // SRAM-like size is log2(bytes) on 2 bits; AXI arsize is the same on 3 bits.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/ar_req_arbiter_if.sv
// Bundles the SRAM-like read ports, write-path events and AXI AR/R channels
// seen by ar_req_arbiter. slave is the arbiter's view, master the surroundings.
interface ar_req_arbiter_if;

  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_rd_req;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic        data_rd_addr_ok;
  logic        data_rd_data_ok;
  logic [31:0] data_rd_rdata;

  logic        aw_fire;
  logic        b_fire;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  inst_sram_req, inst_sram_size, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_rd_req, data_sram_size, data_sram_addr,
    output data_rd_addr_ok, data_rd_data_ok, data_rd_rdata,
    input  aw_fire, b_fire,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport master (
    output inst_sram_req, inst_sram_size, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_rd_req, data_sram_size, data_sram_addr,
    input  data_rd_addr_ok, data_rd_data_ok, data_rd_rdata,
    output aw_fire, b_fire,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter: holds on simultaneous inc+dec, never wraps
// below zero or above all-ones. Synchronous active-low reset.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // NOTE: state is updated with non-blocking assignments and reset is sampled
  // on the clock edge only, so reset never appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/ar_req_arbiter.sv
// Shares the AXI AR/R channels between the instruction and data read ports.
// Optional macro AR_ROUND_ROBIN_EN: alternate grants on contention (default: data first).
module ar_req_arbiter
  import sram2axi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic            clk,
  input  logic            reset,
  ar_req_arbiter_if.slave bus
);

  ar_state_e        state_q, state_d;
  ar_req_t          ar_q, ar_d;
  logic [CNT_W-1:0] inst_cnt, data_cnt, wr_pend;
  logic             inst_elig, data_elig, pick_data;
  logic             grant_inst, grant_data;
  logic             inst_ret, data_ret;
  logic             unused_r_fields;

  // A data read may not pass a write that has issued AW but not yet seen B;
  // the aw_fire term covers the write whose AW fires in this very cycle.
  assign inst_elig = bus.inst_sram_req & (inst_cnt < CNT_W'(MAX_OUTSTANDING));
  assign data_elig = bus.data_sram_rd_req & (data_cnt < CNT_W'(MAX_OUTSTANDING))
                   & (wr_pend == '0) & ~bus.aw_fire;

`ifdef AR_ROUND_ROBIN_EN
  logic favour_data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      favour_data_q <= 1'b1;
    end else if (grant_inst || grant_data) begin
      favour_data_q <= grant_inst;
    end
  end

  assign pick_data = data_elig & (~inst_elig | favour_data_q);
`else
  assign pick_data = data_elig;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    ar_d       = ar_q;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset) begin
          grant_data = pick_data;
          grant_inst = inst_elig & ~pick_data;
          if (grant_data) begin
            ar_d    = '{addr: bus.data_sram_addr, size: axi_size(bus.data_sram_size), id: ID_DATA};
            state_d = ISSUE;
          end else if (grant_inst) begin
            ar_d    = '{addr: bus.inst_sram_addr, size: axi_size(bus.inst_sram_size), id: ID_INST};
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.arready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
    end
  end

  assign bus.inst_sram_addr_ok = grant_inst;
  assign bus.data_rd_addr_ok   = grant_data;

  assign bus.arvalid = (state_q == ISSUE);
  assign bus.araddr  = ar_q.addr;
  assign bus.arid    = ar_q.id;
  assign bus.arsize  = ar_q.size;
  assign bus.arlen   = LEN_SINGLE;
  assign bus.arburst = BURST_INCR;
  assign bus.arlock  = LOCK_NORMAL;
  assign bus.arcache = CACHE_NONE;
  assign bus.arprot  = PROT_NONE;

  // Only rid[0] distinguishes the two requesters; beats are always single.
  assign bus.rready  = 1'b1;
  assign inst_ret    = reset & bus.rvalid & (bus.rid[0] == ID_INST[0]);
  assign data_ret    = reset & bus.rvalid & (bus.rid[0] == ID_DATA[0]);

  assign bus.inst_sram_data_ok = inst_ret;
  assign bus.data_rd_data_ok   = data_ret;
  assign bus.inst_sram_rdata   = bus.rdata;
  assign bus.data_rd_rdata     = bus.rdata;

  assign unused_r_fields = ^{bus.rid[3:1], bus.rresp, bus.rlast};

  sat_updown_cnt #(.W(CNT_W)) u_inst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_inst),
    .dec   (inst_ret),
    .count (inst_cnt)
  );

  sat_updown_cnt #(.W(CNT_W)) u_data_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_data),
    .dec   (data_ret),
    .count (data_cnt)
  );

  sat_updown_cnt #(.W(CNT_W)) u_wr_pend (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.aw_fire),
    .dec   (bus.b_fire),
    .count (wr_pend)
  );

endmodule

// File: tb/tb_ar_req_arbiter.sv
// Scoreboard bench for ar_req_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of the arbitration rules.
module tb_ar_req_arbiter;
  import sram2axi_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int WR_MAX  = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ar_req_arbiter_if bus();

  ar_req_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit ok_i;
    bit ok_d;
    bit arv;
    bit dok_i;
    bit dok_d;
  } cyc_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  id;
  } ar_exp_t;

  cyc_exp_t    cyc_q[$];
  ar_exp_t     ar_q[$];
  logic [31:0] rdata_q[$];

  int total = 0;
  int bad   = 0;

  // Model state: reads granted and not yet returned per requester, writes
  // awaiting B, whether an AR is on the bus, and who won the last grant.
  int m_inst = 0, m_data = 0, m_wr = 0;
  bit m_busy = 1'b0;
  bit m_busy_id = 1'b0;
  bit m_last_inst = 1'b1;
  // Bench AXI slave: reads accepted on AR that still owe an R beat.
  int acc_inst = 0, acc_data = 0;
  int wr_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_step(input int v, input bit inc, input bit dec, input int maxv);
    if (inc && !dec) return (v < maxv) ? v + 1 : v;
    if (dec && !inc) return (v > 0) ? v - 1 : v;
    return v;
  endfunction

  // One clock cycle: inputs are already set; predict this cycle's outputs,
  // queue them for the monitor, then advance to the next falling edge.
  task automatic cycle();
    cyc_exp_t e;
    bit in_rst, ie, de, gi, gd, arf, aw, b;
    e      = '{default: 0};
    in_rst = !reset;
    gi     = 1'b0;
    gd     = 1'b0;
    aw     = bus.aw_fire;
    b      = bus.b_fire;
    arf    = m_busy && bus.arready && !in_rst;
    e.arv  = m_busy;
    if (!in_rst) begin
      if (!m_busy) begin
        ie = bus.inst_sram_req && (m_inst < MAX_OUT);
        de = bus.data_sram_rd_req && (m_data < MAX_OUT) && (m_wr == 0) && !aw;
        if (ie && de) begin
`ifdef AR_ROUND_ROBIN_EN
          gd = m_last_inst;
`else
          gd = 1'b1;
`endif
          gi = !gd;
        end else begin
          gi = ie;
          gd = de;
        end
      end
      e.ok_i  = gi;
      e.ok_d  = gd;
      e.dok_i = bus.rvalid && !bus.rid[0];
      e.dok_d = bus.rvalid && bus.rid[0];
      if (bus.rvalid) rdata_q.push_back(bus.rdata);
      if (gi) ar_q.push_back('{addr: bus.inst_sram_addr, size: {1'b0, bus.inst_sram_size}, id: 4'd0});
      if (gd) ar_q.push_back('{addr: bus.data_sram_addr, size: {1'b0, bus.data_sram_size}, id: 4'd1});
    end
    cyc_q.push_back(e);
    @(negedge clk);
    if (in_rst) begin
      m_inst = 0; m_data = 0; m_wr = 0;
      m_busy = 1'b0; m_last_inst = 1'b1;
      acc_inst = 0; acc_data = 0;
      ar_q.delete();
    end else begin
      m_inst = sat_step(m_inst, gi, e.dok_i, WR_MAX);
      m_data = sat_step(m_data, gd, e.dok_d, WR_MAX);
      m_wr   = sat_step(m_wr, aw, b, WR_MAX);
      if (arf) begin
        m_busy = 1'b0;
        if (m_busy_id) acc_data++; else acc_inst++;
      end
      if (gi || gd) begin
        m_busy      = 1'b1;
        m_busy_id   = gd;
        m_last_inst = gi;
      end
    end
    if (gi) bus.inst_sram_req = 1'b0;
    if (gd) bus.data_sram_rd_req = 1'b0;
    bus.rvalid  = 1'b0;
    bus.aw_fire = 1'b0;
    bus.b_fire  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_r(input bit id);
    bus.rvalid = 1'b1;
    bus.rid    = {3'($urandom_range(0, 7)), id};
    bus.rdata  = $urandom;
    bus.rresp  = 2'($urandom_range(0, 3));
    bus.rlast  = 1'b1;
    if (id) begin
      if (acc_data > 0) acc_data--;
    end else if (acc_inst > 0) begin
      acc_inst--;
    end
  endtask

  task automatic drain_r();
    for (int i = 0; i < 40 && (acc_inst + acc_data) > 0; i++) begin
      send_r(acc_data > 0);
      cycle();
    end
  endtask

  task automatic req_inst(input logic [31:0] addr, input logic [1:0] size);
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = addr;
    bus.inst_sram_size = size;
  endtask

  task automatic req_data(input logic [31:0] addr, input logic [1:0] size);
    bus.data_sram_rd_req = 1'b1;
    bus.data_sram_addr   = addr;
    bus.data_sram_size   = size;
  endtask

  // Monitor: compares whatever the DUT presents against the queued predictions.
  initial begin
    cyc_exp_t e;
    ar_exp_t  a;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("inst_addr_ok", bus.inst_sram_addr_ok, e.ok_i);
        check("data_addr_ok", bus.data_rd_addr_ok, e.ok_d);
        check("arvalid", bus.arvalid, e.arv);
        check("inst_data_ok", bus.inst_sram_data_ok, e.dok_i);
        check("data_data_ok", bus.data_rd_data_ok, e.dok_d);
        check("rready", bus.rready, 1);
        if (bus.arvalid) begin
          if (ar_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ar_extra: arvalid high with addr 0x%0h, none expected", bus.araddr);
          end else begin
            a = ar_q[0];
            check("araddr", bus.araddr, a.addr);
            check("arid", bus.arid, a.id);
            check("arsize", bus.arsize, a.size);
            check("arlen", bus.arlen, 0);
            check("arburst", bus.arburst, 1);
            check("arlock_cache_prot", {bus.arlock, bus.arcache, bus.arprot}, 0);
            if (bus.arready) void'(ar_q.pop_front());
          end
        end
        if (bus.inst_sram_data_ok || bus.data_rd_data_ok) begin
          if (rdata_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL r_extra: data_ok with rdata 0x%0h, none expected", bus.rdata);
          end else begin
            d = rdata_q.pop_front();
            check("inst_rdata", bus.inst_sram_rdata, d);
            check("data_rdata", bus.data_rd_rdata, d);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.inst_sram_req = 1'b0;  bus.inst_sram_size = 2'd0; bus.inst_sram_addr = '0;
    bus.data_sram_rd_req = 1'b0; bus.data_sram_size = 2'd0; bus.data_sram_addr = '0;
    bus.aw_fire = 1'b0; bus.b_fire = 1'b0; bus.arready = 1'b0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    @(negedge clk);
    idle(2);
    check("reset_araddr", bus.araddr, 0);
    check("reset_arid", bus.arid, 0);
    check("reset_arsize", bus.arsize, 0);
    reset = 1'b1;

    // Single instruction read, accepted on AR in its second ISSUE cycle.
    req_inst(32'h1000, 2'd2);
    cycle();
    cycle();
    bus.arready = 1'b1;
    cycle();
    bus.arready = 1'b0;
    send_r(1'b0);
    bus.rdata = 32'hDEADBEEF;
    cycle();
    idle(2);

    // Contention twice: fixed priority serves data first both times.
    bus.arready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_inst(32'h2000 + 32'(k * 16), 2'd2);
      req_data(32'h3000 + 32'(k * 16), 2'd1);
      idle(5);
    end
    drain_r();

    // Write ordering: a read launched alongside AW, then held until B.
    bus.aw_fire = 1'b1;
    req_data(32'h4000, 2'd2);
    cycle();
    req_inst(32'h5000, 2'd0);
    idle(4);
    bus.b_fire = 1'b1;
    cycle();
    idle(3);
    drain_r();

    // Outstanding limit on the instruction side.
    for (int i = 0; i < 14; i++) begin
      if (!bus.inst_sram_req) req_inst(32'h6000 + 32'(i * 4), 2'd2);
      cycle();
    end
    send_r(1'b0);
    cycle();
    idle(3);
    drain_r();

    // AR back-pressure: fields stable, no further accepts.
    bus.arready = 1'b0;
    req_inst(32'h7000, 2'd1);
    cycle();
    req_inst(32'h7100, 2'd2);
    req_data(32'h7200, 2'd0);
    idle(10);
    bus.arready = 1'b1;
    idle(6);
    drain_r();

    // Reset while an AR is on the bus, with a write pending and a beat arriving.
    bus.arready = 1'b0;
    bus.aw_fire = 1'b1;
    cycle();
    req_inst(32'h8000, 2'd2);
    cycle();
    cycle();
    reset = 1'b0;
    send_r(1'b1);
    cycle();
    check("rst_mid_araddr", bus.araddr, 0);
    reset = 1'b1;
    req_data(32'h9000, 2'd2);
    send_r(1'b1);
    cycle();
    bus.arready = 1'b1;
    idle(3);
    drain_r();

    // Random traffic.
    wr_out = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.inst_sram_req && $urandom_range(0, 99) < 40)
        req_inst($urandom, 2'($urandom_range(0, 2)));
      if (!bus.data_sram_rd_req && $urandom_range(0, 99) < 30)
        req_data($urandom, 2'($urandom_range(0, 2)));
      bus.arready = ($urandom_range(0, 99) < 60);
      if (wr_out > 0 && $urandom_range(0, 99) < 25) begin
        bus.b_fire = 1'b1;
        wr_out--;
      end
      if (wr_out < 3 && $urandom_range(0, 99) < 6) begin
        bus.aw_fire = 1'b1;
        wr_out++;
      end
      if ((acc_inst + acc_data) > 0 && $urandom_range(0, 99) < 45) begin
        if (acc_inst > 0 && (acc_data == 0 || $urandom_range(0, 1) == 1)) send_r(1'b0);
        else send_r(1'b1);
      end
      cycle();
    end

    // Wind down: let held requests finish and return every beat.
    bus.arready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (wr_out > 0) begin
        bus.b_fire = 1'b1;
        wr_out--;
      end
      if ((acc_inst + acc_data) > 0) send_r(acc_data > 0);
      cycle();
    end
    idle(3);
    #3;
    check("ar_queue_drained", ar_q.size(), 0);
    check("r_queue_drained", rdata_q.size(), 0);
    check("req_inst_served", bus.inst_sram_req, 0);
    check("req_data_served", bus.data_sram_rd_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
